// File: rtl/seq_signed_mult_if.sv
// Handshake bundle for seq_signed_mult: operand channel in, product channel out.
// With SEQ_SIGNED_MULT_ACC_EN defined the bundle also carries acc_clr.
interface seq_signed_mult_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out;
`ifdef SEQ_SIGNED_MULT_ACC_EN
   logic                 acc_clr;
`endif

   // producer of operands / consumer of results
   modport master (
      output in_valid, a, b, out_ready,
`ifdef SEQ_SIGNED_MULT_ACC_EN
      output acc_clr,
`endif
      input  in_ready, out_valid, out
   );

   // the multiplier itself
   modport slave (
      input  in_valid, a, b, out_ready,
`ifdef SEQ_SIGNED_MULT_ACC_EN
      input  acc_clr,
`endif
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/seq_signed_mult.sv
// Iterative signed multiplier, radix-2 Booth, one step per clock.
// Optional running accumulator enabled by defining SEQ_SIGNED_MULT_ACC_EN.
//
// state | meaning
// IDLE  | ready for operands, in_ready=1
// RUN   | WIDTH Booth steps in progress
// DONE  | result registered on out, out_valid=1 until out_ready
module seq_signed_mult #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   seq_signed_mult_if.slave   bus
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state, state_nxt;
   logic                 in_ready, out_valid;
   logic [WIDTH:0]       m;          // multiplicand, sign-extended by one bit
   logic [WIDTH:0]       part;       // Booth partial accumulator (extra bit for -(-2^(W-1)))
   logic [WIDTH-1:0]     q;          // multiplier, shifted out LSB first
   logic                 q_m1;
   logic [CNT_W-1:0]     count;
   logic [2*WIDTH-1:0]   out_r;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH:0]     shifted;
   logic [2*WIDTH-1:0]   product;
   logic                 last_step;

   assign last_step = (count == CNT_W'(WIDTH-1));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last_step) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // one Booth step: add/sub M by {q0,q-1}, then arithmetic shift right of {part,q}
   always_comb begin
      sum = part;
      case ({q[0], q_m1})
         2'b10:   sum = part - m;
         2'b01:   sum = part + m;
         default: sum = part;
      endcase
   end

   assign shifted = {sum[WIDTH], sum, q[WIDTH-1:1]};
   assign product = shifted[2*WIDTH-1:0];

`ifdef SEQ_SIGNED_MULT_ACC_EN
   logic                 clr_l;
   logic [2*WIDTH-1:0]   acc_total;
   logic [2*WIDTH-1:0]   acc_nxt;

   // running sum wraps modulo 2^(2*WIDTH)
   assign acc_nxt = (clr_l ? '0 : acc_total) + product;

   // accumulator and its clear flag, captured with the operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_l     <= 1'b0;
         acc_total <= '0;
      end else if (state == IDLE && bus.in_valid) begin
         clr_l <= bus.acc_clr;
      end else if (state == RUN && last_step) begin
         acc_total <= acc_nxt;
      end
   end
`endif

   // operand capture, Booth iteration and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m     <= '0;
         part  <= '0;
         q     <= '0;
         q_m1  <= 1'b0;
         count <= '0;
         out_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  m     <= {bus.a[WIDTH-1], bus.a};
                  q     <= bus.b;
                  part  <= '0;
                  q_m1  <= 1'b0;
                  count <= '0;
               end
            end
            RUN: begin
               part  <= shifted[2*WIDTH:WIDTH];
               q     <= shifted[WIDTH-1:0];
               q_m1  <= q[0];
               count <= count + 1'b1;
               if (last_step) begin
`ifdef SEQ_SIGNED_MULT_ACC_EN
                  out_r <= acc_nxt;
`else
                  out_r <= product;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out       = out_r;
endmodule
